// File: rtl/serial_adder.sv
// serial_adder: bit-serial unsigned adder, LSB first, one full-adder cell.
// A start accepted at edge E0 produces Sum/Carry/done after edge E0+WIDTH.
//
// state | meaning
// IDLE  | waiting for start, outputs hold the last result
// RUN   | one operand bit consumed per clock, busy high
// DONE  | one-cycle done pulse; start here restarts with no idle gap
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_nxt;
    logic             carry_r;
    logic [CW-1:0]    count;
    logic             accept;
    logic             last_bit;
    logic             bit_sum;
    logic             bit_carry;

    // The operand shift registers present bit[count] at their LSB.
    assign bit_sum   = a_sh[0] ^ b_sh[0] ^ carry_r;
    assign bit_carry = (a_sh[0] & b_sh[0]) | (carry_r & (a_sh[0] ^ b_sh[0]));
    assign res_nxt   = {bit_sum, res_sh[WIDTH-1:1]};
    assign last_bit  = (count == LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and Moore status outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, per-bit add/shift, and result load on the final bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            carry_r <= 1'b0;
            count   <= '0;
            Sum     <= '0;
            Carry   <= 1'b0;
        end else if (accept) begin
            a_sh    <= in1;
            b_sh    <= in2;
            carry_r <= Cin;
            count   <= '0;
        end else if (state == RUN) begin
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            carry_r <= bit_carry;
            res_sh  <= res_nxt;
            count   <= count + CW'(1);
            // Outputs only move here so they hold the previous result while running.
            if (last_bit) begin
                Sum   <= res_nxt;
                Carry <= bit_carry;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder (WIDTH=8): directed literal cases plus random
// operations, with a cycle-level reference model checked every cycle.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         Cin;
    logic         busy;
    logic         done;
    logic [W-1:0] Sum;
    logic         Carry;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    bit chk_en = 0;

    // Reference model: an accepted operation completes WIDTH edges later.
    int           m_left = 0;
    logic [W:0]   m_pend = '0;
    logic [W-1:0] m_sum = '0;
    logic         m_carry = 1'b0;
    logic         m_done = 1'b0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .in1   (in1),
        .in2   (in2),
        .Cin   (Cin),
        .busy  (busy),
        .done  (done),
        .Sum   (Sum),
        .Carry (Carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model update on each rising edge.
    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (!rst_n) begin
            m_left  <= 0;
            m_done  <= 1'b0;
            m_sum   <= '0;
            m_carry <= 1'b0;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            m_done <= (m_left == 1);
            if (m_left == 1) {m_carry, m_sum} <= m_pend;
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_pend <= {1'b0, in1} + {1'b0, in2} + {{W{1'b0}}, Cin};
                m_left <= W;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_busy",  {31'd0, busy},  {31'd0, m_left != 0});
            check("model_done",  {31'd0, done},  {31'd0, m_done});
            check("model_sum",   {24'd0, Sum},   {24'd0, m_sum});
            check("model_carry", {31'd0, Carry}, {31'd0, m_carry});
            check("busy_done_excl", {31'd0, busy & done}, 32'd0);
        end
    end

    // Issue one operation from an idle/done negedge; returns at the done negedge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input string nm, input logic [W-1:0] es, input logic ec);
        int n;
        int k;
        in1 = a; in2 = b; Cin = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in1 = W'($urandom); in2 = W'($urandom); Cin = 1'($urandom);
        n = 0;
        k = 0;
        while (!done && k < 20) begin
            if (busy) n++;
            k++;
            @(negedge clk);
        end
        check({nm, "_done_seen"}, {31'd0, done}, 32'd1);
        check({nm, "_busy_cycles"}, n, W);
        check({nm, "_sum"}, {24'd0, Sum}, {24'd0, es});
        check({nm, "_carry"}, {31'd0, Carry}, {31'd0, ec});
    endtask

    initial begin
        int d0;
        int k;
        logic [W-1:0] ra, rb;
        logic         rc;
        logic [W:0]   rexp;

        rst_n = 1'b0; start = 1'b0; in1 = '0; in2 = '0; Cin = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy",  {31'd0, busy},  32'd0);
        check("rst_done",  {31'd0, done},  32'd0);
        check("rst_sum",   {24'd0, Sum},   32'd0);
        check("rst_carry", {31'd0, Carry}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic addition and overflow cases.
        d0 = done_cnt;
        run_op(8'h3C, 8'h42, 1'b0, "add_3c_42", 8'h7E, 1'b0);
        @(negedge clk);
        check("add_3c_42_one_done", done_cnt - d0, 1);
        run_op(8'hFF, 8'h01, 1'b0, "add_ff_01", 8'h00, 1'b1);
        @(negedge clk);
        run_op(8'hA5, 8'h5A, 1'b1, "add_a5_5a_c", 8'h00, 1'b1);
        @(negedge clk);

        // start held high through RUN with operands scrambled mid-run.
        d0 = done_cnt;
        in1 = 8'h12; in2 = 8'h34; Cin = 1'b0; start = 1'b1;
        @(negedge clk);
        k = 0;
        while (!done && k < 20) begin
            in1 = W'($urandom); in2 = W'($urandom); Cin = 1'($urandom);
            k++;
            @(negedge clk);
        end
        start = 1'b0;
        check("hold_start_latency", k, W);
        check("hold_start_sum", {24'd0, Sum}, 32'h46);
        check("hold_start_carry", {31'd0, Carry}, 32'd0);
        repeat (10) @(negedge clk);
        check("hold_start_one_done", done_cnt - d0, 1);

        // Back-to-back: start in the DONE cycle.
        run_op(8'h10, 8'h20, 1'b0, "b2b_first", 8'h30, 1'b0);
        in1 = 8'h01; in2 = 8'h01; Cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            check("b2b_busy", {31'd0, busy}, 32'd1);
            check("b2b_sum_hold", {24'd0, Sum}, 32'h30);
            @(negedge clk);
        end
        check("b2b_done", {31'd0, done}, 32'd1);
        check("b2b_sum", {24'd0, Sum}, 32'h02);
        check("b2b_carry", {31'd0, Carry}, 32'd0);
        @(negedge clk);

        // Reset in the 4th RUN cycle aborts with no done pulse.
        run_op(8'h55, 8'h66, 1'b0, "pre_rst", 8'hBB, 1'b0);
        @(negedge clk);
        in1 = 8'h0F; in2 = 8'h0F; Cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_run_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_run_busy",  {31'd0, busy},  32'd0);
        check("rst_run_done",  {31'd0, done},  32'd0);
        check("rst_run_sum",   {24'd0, Sum},   32'd0);
        check("rst_run_carry", {31'd0, Carry}, 32'd0);
        rst_n = 1'b1;
        d0 = done_cnt;
        repeat (12) @(negedge clk);
        check("rst_run_no_done", done_cnt - d0, 0);

        // Random operations, some back-to-back.
        for (int t = 0; t < 256; t++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            rexp = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op(ra, rb, rc, "rand", rexp[W-1:0], rexp[W]);
        end
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: the reset; it is synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an addition; sampled on the clk rising edge.
REQ-005 The block SHALL have port in1, input, WIDTH bits: operand A; captured when start is accepted.
REQ-006 The block SHALL have port in2, input, WIDTH bits: operand B; captured when start is accepted.
REQ-007 The block SHALL have port Cin, input, 1 bit: carry-in; captured when start is accepted.
REQ-008 The block SHALL have port busy, output, 1 bit: high while bits are being processed.
REQ-009 The block SHALL have port done, output, 1 bit: single-cycle pulse marking a valid result.
REQ-010 The block SHALL have port Sum, output, WIDTH bits: registered result, (in1+in2+Cin) mod 2^WIDTH.
REQ-011 The block SHALL have port Carry, output, 1 bit: registered carry-out of the WIDTH-bit addition.

Function
REQ-012 The block SHALL perform the addition bit-serially, LSB first, through one 1-bit full-adder cell: one bit per clock, with the carry held in a 1-bit register between bits.
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 In IDLE or DONE, start=1 at an edge SHALL cause the following at that edge: capture in1/in2 into shift registers, load the carry register with Cin, clear the bit counter, and enter RUN.
REQ-015 In RUN, each edge SHALL add bit[count] of both operands plus the carry register, shift the sum bit into an internal result shift register (MSB side), update the carry register, and increment count.
REQ-016 On the edge that processes bit WIDTH-1, the FSM SHALL enter DONE and load Sum with the internal result and Carry with the final carry, both at that same edge.
REQ-017 Latency SHALL be fixed: for a start accepted at edge E0, Sum/Carry/done become valid after edge E_WIDTH; with WIDTH=8 that is the 8th edge after E0.
REQ-018 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE (one cycle); busy and done SHALL never be high together.
REQ-019 DONE without start SHALL return to IDLE at the next edge; DONE with start SHALL go directly to RUN (back-to-back operation, no idle gap).
REQ-020 start while in RUN SHALL be ignored; operands, count and outputs SHALL be unaffected.
REQ-021 Sum and Carry SHALL change only at the completing edge (REQ-016) or on reset; between completions they SHALL hold the last result, including while a new operation runs.
REQ-022 Changes to in1/in2/Cin after the accepting edge SHALL not affect the operation in progress.
REQ-023 Arithmetic SHALL be unsigned; overflow appears only on Carry, and Sum wraps modulo 2^WIDTH.

Reset
REQ-024 When rst_n=0 at a rising edge, the block SHALL enter IDLE with busy=0, done=0, Sum=0, Carry=0, and the counter, carry register and shift registers all cleared.
REQ-025 Reset SHALL take priority over start and over any state; reset during RUN SHALL abort the operation with no done pulse, and the outputs SHALL read 0.
REQ-026 With rst_n=1, no output SHALL change without clk.

Verification (WIDTH=8)
REQ-027 The bench SHALL check: in1=0x3C, in2=0x42, Cin=0, start pulse -> busy=1 for 8 cycles, then done=1 for 1 cycle, Sum=0x7E, Carry=0.
REQ-028 The bench SHALL check: in1=0xFF, in2=0x01, Cin=0 -> Sum=0x00, Carry=1; then in1=0xA5, in2=0x5A, Cin=1 -> Sum=0x00, Carry=1.
REQ-029 The bench SHALL check: start held high through RUN, with operands changed mid-run -> the result matches the originally captured operands and exactly one done pulse occurs.
REQ-030 The bench SHALL check: start asserted in the DONE cycle with in1=0x01, in2=0x01, Cin=0 -> RUN entered immediately; the previous Sum holds for 8 cycles, then Sum=0x02, Carry=0.
REQ-031 The bench SHALL check: rst_n=0 for one edge at the 4th RUN cycle -> busy=0, done=0, Sum=0x00, Carry=0 at that edge, and no done pulse follows.
REQ-032 The bench SHALL check: 256 random operand/Cin sets against a {Carry,Sum} = in1+in2+Cin reference model, with a latency check on every operation.
